// File: rtl/clause_dispatcher.sv
// clause_dispatcher: buffers incoming clause words in a small FIFO and hands
// each one to exactly one downstream clause queue, choosing the queue
// round-robin among those that are enabled and not full. A flush request
// stops intake, lets the buffer drain, then pulses flush_done once.
module clause_dispatcher #(
  parameter int NUM_Q      = 4,
  parameter int CLAUSE_W   = 4,
  parameter int ELEM_BITS  = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [CLAUSE_W*ELEM_BITS-1:0] in_data,
  output logic                          in_ready,
  input  logic [NUM_Q-1:0]              q_full,
  input  logic [NUM_Q-1:0]              q_enable,
  output logic [NUM_Q-1:0]              q_valid,
  output logic [CLAUSE_W*ELEM_BITS-1:0] q_data,
  input  logic                          flush_req,
  output logic                          flush_done,
  output logic                          busy,
  output logic [15:0]                   dispatch_cnt
);

  localparam int CW   = CLAUSE_W * ELEM_BITS;
  // Pointer width kept at least 1 so a single-entry buffer still elaborates.
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Count must be able to hold FIFO_DEPTH itself.
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_reg;
  state_t          state_next;

  logic [CW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW-1:0]   wr_ptr_reg;
  logic [CNTW-1:0] count_reg;

  logic [NUM_Q-1:0] rr_base_reg;
  logic [NUM_Q-1:0] rr_base_next;
  logic [15:0]      dispatch_cnt_reg;

  logic [NUM_Q-1:0] eligible;
  logic [NUM_Q-1:0] rot_elig;
  logic [NUM_Q-1:0] first_hot;
  logic [NUM_Q-1:0] grant;
  logic [NUM_Q-1:0] rot_terms   [NUM_Q];
  logic [NUM_Q-1:0] grant_terms [NUM_Q];

  logic fifo_nonempty;
  logic dispatch;
  logic push;
  logic run_ready;

  // Wrap-around increment that does not rely on the depth being a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  assign eligible      = ~q_full & q_enable;
  assign fifo_nonempty = (count_reg != '0);
  // Reset suppresses the strobe so nothing leaks downstream while held.
  assign dispatch      = fifo_nonempty && (eligible != '0) && !reset;
  // Intake depends only on registered state; a pop in the same cycle does
  // not open a slot early.
  assign run_ready     = (count_reg < CNTW'(FIFO_DEPTH)) && !reset;
  assign push          = in_valid && in_ready;

  // Round-robin search expressed as constant-index rotations:
  // rot_elig[i] is the eligibility of the queue i positions above rr_base.
  generate
    for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_rot
      for (genvar gj = 0; gj < NUM_Q; gj++) begin : g_rot_term
        assign rot_terms[gi][gj] = rr_base_reg[gj] & eligible[(gj + gi) % NUM_Q];
        // Map an offset hit back to an absolute queue number.
        assign grant_terms[gi][gj] = first_hot[gj] & rr_base_reg[(gi + NUM_Q - gj) % NUM_Q];
      end
      assign rot_elig[gi] = |rot_terms[gi];
      assign grant[gi]    = |grant_terms[gi];
      // Next base is the granted queue rotated up by one position.
      assign rr_base_next[(gi + 1) % NUM_Q] = grant[gi];
    end
  endgenerate

  // Pick the lowest offset from rr_base that has an eligible queue.
  always_comb begin
    logic found;
    found     = 1'b0;
    first_hot = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (rot_elig[i] && !found) begin
        first_hot[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  // Flush state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Flush next-state and the state-dependent handshake outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    flush_done = 1'b0;
    case (state_reg)
      ST_RUN: begin
        in_ready = run_ready;
        if (flush_req) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Completion is judged on the count at the start of the cycle, so an
        // empty buffer still spends one cycle here.
        if (!fifo_nonempty) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        flush_done = !reset;
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // FIFO pointers and occupancy; simultaneous push and pop keeps the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (dispatch) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({push, dispatch})
        2'b10:   count_reg <= count_reg + CNTW'(1);
        2'b01:   count_reg <= count_reg - CNTW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Clause storage; contents need no reset because count gates every read.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= in_data;
    end
  end

  // Round-robin base and dispatch counter advance only on a dispatch.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_base_reg      <= NUM_Q'(1);
      dispatch_cnt_reg <= '0;
    end else if (dispatch) begin
      rr_base_reg      <= rr_base_next;
      dispatch_cnt_reg <= dispatch_cnt_reg + 16'd1;
    end
  end

  assign q_valid      = dispatch ? grant : '0;
  assign q_data       = fifo_nonempty ? fifo_mem[rd_ptr_reg] : '0;
  assign busy         = (fifo_nonempty || (state_reg != ST_RUN)) && !reset;
  assign dispatch_cnt = dispatch_cnt_reg;

endmodule

// File: tb/tb_clause_dispatcher.sv
// Scoreboard bench for clause_dispatcher: accepted clauses are queued with
// their data; every cycle the expected strobe is derived from a round-robin
// model and compared with the DUT, and the head clause data is checked.
module tb_clause_dispatcher;

  localparam int NQ = 4;
  localparam int CW = 44;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic [CW-1:0] in_data;
  logic          in_ready;
  logic [NQ-1:0] q_full;
  logic [NQ-1:0] q_enable;
  logic [NQ-1:0] q_valid;
  logic [CW-1:0] q_data;
  logic          flush_req;
  logic          flush_done;
  logic          busy;
  logic [15:0]   dispatch_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [CW-1:0] sb [$];
  logic [NQ-1:0] glog [$];
  logic [NQ-1:0] exp_rr;
  logic [15:0]   exp_cnt;
  int            flush_pulses = 0;
  bit            verbose = 1;

  clause_dispatcher #(
    .NUM_Q(NQ), .CLAUSE_W(4), .ELEM_BITS(11), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .q_full(q_full), .q_enable(q_enable),
    .q_valid(q_valid), .q_data(q_data),
    .flush_req(flush_req), .flush_done(flush_done),
    .busy(busy), .dispatch_cnt(dispatch_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference round-robin: first eligible queue at or above the base index.
  function automatic logic [NQ-1:0] model_grant(input logic [NQ-1:0] base, input logic [NQ-1:0] elig);
    int b = 0;
    for (int i = 0; i < NQ; i++) if (base[i]) b = i;
    for (int i = 0; i < NQ; i++) begin
      int k = (b + i) % NQ;
      if (elig[k]) return NQ'(1) << k;
    end
    return '0;
  endfunction

  function automatic logic [CW-1:0] rand_clause();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[CW-1:0];
  endfunction

  // Per-cycle monitor, sampled on the falling edge.
  initial begin
    logic [NQ-1:0] eg;
    exp_rr  = NQ'(1);
    exp_cnt = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        check_val("rst_in_ready", 64'(in_ready), 64'(0));
        check_val("rst_q_valid", 64'(q_valid), 64'(0));
        check_val("rst_flush_done", 64'(flush_done), 64'(0));
        check_val("rst_busy", 64'(busy), 64'(0));
        sb.delete();
        exp_rr  = NQ'(1);
        exp_cnt = '0;
      end else begin
        eg = (sb.size() != 0) ? model_grant(exp_rr, ~q_full & q_enable) : '0;
        check_val("q_valid", 64'(q_valid), 64'(eg));
        check_val("dispatch_cnt", 64'(dispatch_cnt), 64'(exp_cnt));
        if (flush_done) flush_pulses++;
        if (q_valid != '0) glog.push_back(q_valid);
        if (sb.size() == 0) begin
          check_val("q_data_empty", 64'(q_data), 64'(0));
        end
        if (eg != '0) begin
          check_val("q_data", 64'(q_data), 64'(sb[0]));
          if (verbose) $display("dispatch q_valid=%b data=0x%011h cnt=%0d", q_valid, q_data, exp_cnt + 16'd1);
          void'(sb.pop_front());
          exp_rr  = {eg[NQ-2:0], eg[NQ-1]};
          exp_cnt = exp_cnt + 16'd1;
        end
      end
    end
  end

  // Offer one clause for one cycle; record it on the scoreboard if accepted.
  task automatic push_one(input logic [CW-1:0] d, output bit acc);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clock);
    acc = in_ready;
    @(posedge clock);
    if (acc) sb.push_back(d);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_flush();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check_val("drain_bound", 64'(sb.size()), 64'(0));
    tick();
  endtask

  initial begin
    bit acc;
    int n_acc;
    int cyc;
    int fp0;
    logic [NQ-1:0] seq_a [5];
    logic [NQ-1:0] seq_c [3];
    seq_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    seq_c = '{4'b0001, 4'b0010, 4'b0100};

    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    q_full = '0; q_enable = '1; flush_req = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Post-reset state
    @(negedge clock);
    check_val("init_in_ready", 64'(in_ready), 64'(1));
    check_val("init_busy", 64'(busy), 64'(0));
    check_val("init_q_data", 64'(q_data), 64'(0));
    check_val("init_cnt", 64'(dispatch_cnt), 64'(0));
    tick();

    // Five back-to-back clauses rotate over all queues
    glog.delete();
    for (int i = 0; i < 5; i++) push_one(rand_clause(), acc);
    wait_drain();
    check_val("rr5_len", 64'(glog.size()), 64'(5));
    for (int i = 0; i < 5 && i < glog.size(); i++) check_val("rr5_seq", 64'(glog[i]), 64'(seq_a[i]));
    check_val("rr5_cnt", 64'(dispatch_cnt), 64'(5));

    // Base at queue 1 with queue 1 full: skip to queue 2, next base queue 3
    glog.delete();
    q_full = 4'b0010;
    push_one(rand_clause(), acc);
    wait_drain();
    q_full = '0;
    push_one(rand_clause(), acc);
    wait_drain();
    check_val("skip_len", 64'(glog.size()), 64'(2));
    if (glog.size() == 2) begin
      check_val("skip_full", 64'(glog[0]), 64'(4'b0100));
      check_val("skip_next", 64'(glog[1]), 64'(4'b1000));
    end

    // All queues disabled: buffer fills at four, then queue 3 alone drains it
    q_enable = '0;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      push_one(rand_clause(), acc);
      if (acc) n_acc++;
    end
    check_val("full_accepts", 64'(n_acc), 64'(4));
    check_val("full_last_ready", 64'(acc), 64'(0));
    check_val("full_busy", 64'(busy), 64'(1));
    glog.delete();
    q_enable = 4'b1000;
    wait_drain();
    check_val("en3_len", 64'(glog.size()), 64'(4));
    for (int i = 0; i < glog.size(); i++) check_val("en3_strobe", 64'(glog[i]), 64'(4'b1000));
    q_enable = '1;

    // Flush with three blocked clauses, then unblock
    q_enable = '0;
    for (int i = 0; i < 3; i++) push_one(rand_clause(), acc);
    fp0 = flush_pulses;
    pulse_flush();
    @(negedge clock);
    check_val("drain_in_ready", 64'(in_ready), 64'(0));
    repeat (2) @(negedge clock);
    check_val("drain_stalled", 64'(flush_done), 64'(0));
    check_val("drain_busy", 64'(busy), 64'(1));
    tick();
    glog.delete();
    q_enable = '1;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!flush_done && cyc < 20);
    check_val("flush_latency", 64'(cyc), 64'(5));
    check_val("flush_len", 64'(glog.size()), 64'(3));
    for (int i = 0; i < 3 && i < glog.size(); i++) check_val("flush_seq", 64'(glog[i]), 64'(seq_c[i]));
    @(negedge clock);
    check_val("flush_one_cycle", 64'(flush_done), 64'(0));
    check_val("flush_resume", 64'(in_ready), 64'(1));
    check_val("flush_pulses", 64'(flush_pulses - fp0), 64'(1));
    tick();

    // Flush with an empty buffer: one DRAIN cycle then one DONE cycle
    pulse_flush();
    @(negedge clock);
    check_val("eflush_drain_ready", 64'(in_ready), 64'(0));
    check_val("eflush_drain_done", 64'(flush_done), 64'(0));
    check_val("eflush_busy", 64'(busy), 64'(1));
    @(negedge clock);
    check_val("eflush_done", 64'(flush_done), 64'(1));
    check_val("eflush_done_ready", 64'(in_ready), 64'(0));
    @(negedge clock);
    check_val("eflush_resume", 64'(in_ready), 64'(1));
    check_val("eflush_idle", 64'(busy), 64'(0));
    tick();

    // Reset during DRAIN discards buffered clauses silently
    q_enable = '0;
    for (int i = 0; i < 2; i++) push_one(rand_clause(), acc);
    pulse_flush();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fp0 = flush_pulses;
    q_enable = '1;
    @(negedge clock);
    check_val("rstd_busy", 64'(busy), 64'(0));
    check_val("rstd_q_valid", 64'(q_valid), 64'(0));
    check_val("rstd_cnt", 64'(dispatch_cnt), 64'(0));
    repeat (4) @(negedge clock);
    check_val("rstd_no_flush", 64'(flush_pulses - fp0), 64'(0));
    tick();

    // Counter wrap: 65535 dispatches reach 0xFFFF, one more wraps to zero
    verbose = 0;
    glog.delete();
    for (int i = 0; i < 65535; i++) push_one(CW'(i), acc);
    wait_drain();
    check_val("cnt_ffff", 64'(dispatch_cnt), 64'(16'hFFFF));
    verbose = 1;
    push_one(rand_clause(), acc);
    wait_drain();
    check_val("cnt_wrap", 64'(dispatch_cnt), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/clause_dispatcher.md
CLAUSE_DISPATCHER -- requirements
Module: clause_dispatcher

Interface
REQ-001 Parameter NUM_Q, default 4: number of downstream clause queues.
REQ-002 Parameter CLAUSE_W, default 4: literal slots per clause.
REQ-003 Parameter ELEM_BITS, default 11: bits per literal slot; clause word width CW = CLAUSE_W*ELEM_BITS (44 by default).
REQ-004 Parameter FIFO_DEPTH, default 4: input buffer entries, power of two.
REQ-005 clock  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  upstream clause valid.
REQ-008 in_data  input  CW  upstream clause word.
REQ-009 in_ready  output  1  dispatcher accepts in_data this cycle.
REQ-010 q_full  input  NUM_Q  per-queue full flag; 1 means the queue must not be written.
REQ-011 q_enable  input  NUM_Q  per-queue participation mask; 0 excludes the queue from arbitration.
REQ-012 q_valid  output  NUM_Q  one-hot write strobe; the selected queue captures q_data this cycle.
REQ-013 q_data  output  CW  clause word broadcast to all queues.
REQ-014 flush_req  input  1  single-cycle drain request.
REQ-015 flush_done  output  1  single-cycle pulse when the drain completes.
REQ-016 busy  output  1  high when FIFO count != 0 or state != RUN.
REQ-017 dispatch_cnt  output  16  total dispatches since reset.

Function
REQ-018 Input handshake: accept when in_valid && in_ready; in_ready = (state==RUN) && (count < FIFO_DEPTH), computed from registered state only.
REQ-019 FIFO full with a same-cycle pop: no accept that cycle (in_ready stays 0).
REQ-020 No bypass: minimum latency is 1 cycle from accept to q_valid; clause order is preserved.
REQ-021 Eligibility: eligible = ~q_full & q_enable; a dispatch occurs when count > 0 and eligible != 0.
REQ-022 Grant selection: grant = first eligible bit at or after one-hot rr_base, searching upward with wrap from NUM_Q-1 to 0.
REQ-023 q_valid = grant on a dispatch cycle, otherwise 0; q_data = FIFO head whenever count > 0, else 0.
REQ-024 On a dispatch: pop the head, rr_base <= grant rotated left by one (wrap MSB to bit 0), dispatch_cnt += 1 modulo 2^16.
REQ-025 No dispatch: rr_base, FIFO and dispatch_cnt hold.
REQ-026 Simultaneous push and pop: count unchanged, head advances, new entry written at tail.
REQ-027 FSM states: RUN, DRAIN, DONE.
REQ-028 RUN -> DRAIN on flush_req.
REQ-029 DRAIN: in_ready=0, dispatch continues; DRAIN -> DONE when count==0 at cycle start.
REQ-030 DONE: flush_done=1 for exactly one cycle, in_ready=0, then -> RUN.
REQ-031 flush_req in DRAIN or DONE is ignored; flush_req with an empty FIFO still spends one DRAIN cycle, then one DONE cycle.
REQ-032 q_enable == 0 or all enabled queues full: dispatch stalls indefinitely, DRAIN does not complete, no timeout.
REQ-033 q_full and q_enable are used combinationally in the same cycle; a queue reporting full is never strobed.

Reset
REQ-034 While reset is high, in_ready=0, q_valid=0, flush_done=0, busy=0.
REQ-035 First cycle after reset: state=RUN, count=0, rr_base=1 (queue 0), dispatch_cnt=0, q_data=0.
REQ-036 Reset mid-drain or mid-dispatch discards all buffered clauses without emitting flush_done.

Verification
REQ-037 All queues empty and enabled; push clauses A,B,C,D,E on consecutive cycles -> q_valid = 0001,0010,0100,1000,0001 on cycles 1..5; dispatch_cnt = 5.
REQ-038 q_full=0010 with rr_base at queue 1; push A -> q_valid=0100, next rr_base = queue 3.
REQ-039 q_enable=0000; push 5 clauses -> 4 accepted, in_ready=0 on the fifth; enable 1000 -> four strobes 1000 in FIFO order.
REQ-040 Three clauses buffered, queues blocked; flush_req -> in_ready=0; unblock -> 3 dispatches, DONE one cycle later with a one-cycle flush_done, then in_ready=1.
REQ-041 dispatch_cnt preset to 0xFFFF by 65535 dispatches; one more dispatch -> 0x0000.
REQ-042 Reset asserted in DRAIN with 2 clauses buffered -> next cycle busy=0, q_valid=0, no flush_done.
